// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the normalizer.
// Contents: normalizer FSM state enum, coarse step size, and the
// unsigned/signed mode encodings driven on signed_mode.
package alu_pkg;

    typedef enum logic [1:0] {
        NORM_IDLE  = 2'd0,
        NORM_SHIFT = 2'd1,
        NORM_DONE  = 2'd2
    } norm_state_e;

    localparam int   NORM_STEP     = 8;
    localparam logic NORM_UNSIGNED = 1'b0;
    localparam logic NORM_SIGNED   = 1'b1;

endpackage

// File: rtl/norm_shift_unit_if.sv
// Start/done handshake and result bus of the normalizer.
// Ports (signals):
//   start        request pulse, sampled only while the unit is idle
//   signed_mode  0 = count leading zeros, 1 = count redundant sign bits
//   data_in      operand, sampled with start
//   busy         unit is working or presenting a result
//   done         one-cycle pulse, results valid
//   data_out     normalized operand
//   shift_count  left-shift amount applied (0..WIDTH)
//   zero         operand was all zeros
// Modports: master drives requests (ALU / bench), slave is the normalizer.
interface norm_shift_unit_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_out;
    logic [CNT_W-1:0] shift_count;
    logic             zero;

    modport master (
        output start, signed_mode, data_in,
        input  busy, done, data_out, shift_count, zero
    );

    modport slave (
        input  start, signed_mode, data_in,
        output busy, done, data_out, shift_count, zero
    );
endinterface

// File: rtl/norm_step_detect.sv
// Combinational step decision for the normalizer working register.
// Ports:
//   work         current working register
//   cnt          shift amount applied so far
//   signed_mode  latched mode (NORM_UNSIGNED / NORM_SIGNED)
//   finish       normalization complete this cycle
//   fast_ok      an 8-bit step is safe this cycle
// Optional macro NORM_FAST_STEP_EN enables the 8-bit step check; without
// it fast_ok is constant 0 and the unit advances one bit per cycle.
module norm_step_detect
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] work,
    input  logic [CNT_W-1:0] cnt,
    input  logic             signed_mode,
    output logic             finish,
    output logic             fast_ok
);

    logic last_s;
    assign last_s = (cnt == CNT_W'(WIDTH - 1));

    // Completion: top bit set (unsigned) or sign bit differs from the next (signed).
    always_comb begin
        finish = 1'b0;
        if (signed_mode == NORM_SIGNED) begin
            finish = (work[WIDTH-1] != work[WIDTH-2]) || last_s;
        end else begin
            finish = work[WIDTH-1] || last_s;
        end
    end

`ifdef NORM_FAST_STEP_EN
    logic [NORM_STEP:0] top_s;
    logic               room_s;
    assign top_s  = work[WIDTH-1 -: NORM_STEP + 1];
    // The count may never pass WIDTH-1 through a coarse step.
    assign room_s = ({1'b0, cnt} + (CNT_W + 1)'(NORM_STEP)) <= (CNT_W + 1)'(WIDTH - 1);

    // Coarse step: eight zeros on top, or nine identical sign bits.
    always_comb begin
        fast_ok = 1'b0;
        if (signed_mode == NORM_SIGNED) begin
            fast_ok = room_s && ((&top_s) || ~(|top_s));
        end else begin
            fast_ok = room_s && ~(|top_s[NORM_STEP:1]);
        end
    end
`else
    assign fast_ok = 1'b0;
`endif

endmodule

// File: rtl/norm_shift_unit.sv
// Iterative normalizer: finds the left shift that normalizes an operand
// (leading zeros when unsigned, redundant sign bits when signed) and
// returns that amount with the shifted value, over a start/done handshake.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset; aborts any operation silently
//   bus    norm_shift_unit_if.slave (start, signed_mode, data_in,
//          busy, done, data_out, shift_count, zero)
// Optional macro NORM_FAST_STEP_EN (in norm_step_detect) allows 8-bit
// steps; results are identical, only latency shrinks.
module norm_shift_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    norm_shift_unit_if.slave   bus
);
    import alu_pkg::*;

    norm_state_e      state_r;
    logic [WIDTH-1:0] work_r;
    logic [CNT_W-1:0] cnt_r;
    logic             mode_r;
    logic             zero_pend_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] data_out_r;
    logic [CNT_W-1:0] shift_count_r;
    logic             zero_r;
    logic             finish_s;
    logic             fast_ok_s;

    norm_step_detect #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_detect (
        .work        (work_r),
        .cnt         (cnt_r),
        .signed_mode (mode_r),
        .finish      (finish_s),
        .fast_ok     (fast_ok_s)
    );

    // Control FSM, working register, counter and registered results.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= NORM_IDLE;
            work_r        <= '0;
            cnt_r         <= '0;
            mode_r        <= NORM_UNSIGNED;
            zero_pend_r   <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            data_out_r    <= '0;
            shift_count_r <= '0;
            zero_r        <= 1'b0;
        end else begin
            case (state_r)
                NORM_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        work_r      <= bus.data_in;
                        cnt_r       <= '0;
                        mode_r      <= bus.signed_mode;
                        // A zero operand still spends one cycle in SHIFT so
                        // that its latency matches a zero-shift operand.
                        zero_pend_r <= (bus.data_in == '0);
                        busy_r      <= 1'b1;
                        state_r     <= NORM_SHIFT;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                NORM_SHIFT: begin
                    if (zero_pend_r) begin
                        data_out_r    <= '0;
                        shift_count_r <= (mode_r == NORM_SIGNED) ? CNT_W'(0) : CNT_W'(WIDTH);
                        zero_r        <= 1'b1;
                        done_r        <= 1'b1;
                        state_r       <= NORM_DONE;
                    end else if (finish_s) begin
                        data_out_r    <= work_r;
                        shift_count_r <= cnt_r;
                        zero_r        <= 1'b0;
                        done_r        <= 1'b1;
                        state_r       <= NORM_DONE;
                    end else if (fast_ok_s) begin
                        work_r <= work_r << NORM_STEP;
                        cnt_r  <= cnt_r + CNT_W'(NORM_STEP);
                    end else begin
                        work_r <= {work_r[WIDTH-2:0], 1'b0};
                        cnt_r  <= cnt_r + CNT_W'(1);
                    end
                end
                NORM_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= NORM_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= NORM_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.data_out    = data_out_r;
    assign bus.shift_count = shift_count_r;
    assign bus.zero        = zero_r;

endmodule

// File: tb/tb_norm_shift_unit.sv
// Directed self-checking bench for norm_shift_unit (WIDTH=32).
// Expected values are hand-computed; latency expectations follow the
// NORM_FAST_STEP_EN build option.
module tb_norm_shift_unit;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    norm_shift_unit_if #(.WIDTH(32)) bus();

    norm_shift_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] op;
        logic        mode;
        logic [31:0] exp_q;
        logic [5:0]  exp_sc;
        logic        exp_z;
        int          lat_slow;
        int          lat_fast;
    } vec_t;

    // Issue one request from IDLE and wait (bounded) for its done pulse.
    task automatic run_op(input logic [31:0] op, input logic mode,
                          output logic [31:0] q, output logic [5:0] sc,
                          output logic z, output int lat,
                          output logic held, output logic pulse_ok);
        logic [31:0] prev_q;
        logic [5:0]  prev_sc;
        logic        prev_z;
        prev_q  = bus.data_out;
        prev_sc = bus.shift_count;
        prev_z  = bus.zero;
        bus.start       = 1'b1;
        bus.data_in     = op;
        bus.signed_mode = mode;
        @(posedge clock); #1;
        bus.start = 1'b0;
        lat  = -1;
        held = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clock); #1;
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
            if (bus.data_out !== prev_q || bus.shift_count !== prev_sc || bus.zero !== prev_z)
                held = 1'b0;
        end
        q  = bus.data_out;
        sc = bus.shift_count;
        z  = bus.zero;
        @(posedge clock); #1;
        pulse_ok = (bus.done === 1'b0) && (bus.busy === 1'b0);
    endtask

    task automatic check_vectors(input string tag, input vec_t v[]);
        logic [31:0] q;
        logic [5:0]  sc;
        logic        z;
        int          lat;
        int          exp_lat;
        logic        held;
        logic        pulse_ok;
        foreach (v[i]) begin
`ifdef NORM_FAST_STEP_EN
            exp_lat = v[i].lat_fast;
`else
            exp_lat = v[i].lat_slow;
`endif
            run_op(v[i].op, v[i].mode, q, sc, z, lat, held, pulse_ok);
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL %s_latency op=%h: got %0d expected %0d", tag, v[i].op, lat, exp_lat);
            end
            checks++;
            if (q !== v[i].exp_q) begin
                errors++;
                $display("FAIL %s_data_out op=%h: got %h expected %h", tag, v[i].op, q, v[i].exp_q);
            end
            checks++;
            if (sc !== v[i].exp_sc) begin
                errors++;
                $display("FAIL %s_shift_count op=%h: got %0d expected %0d", tag, v[i].op, sc, v[i].exp_sc);
            end
            checks++;
            if (z !== v[i].exp_z) begin
                errors++;
                $display("FAIL %s_zero op=%h: got %b expected %b", tag, v[i].op, z, v[i].exp_z);
            end
            checks++;
            if (held !== 1'b1) begin
                errors++;
                $display("FAIL %s_hold op=%h: outputs changed before done", tag, v[i].op);
            end
            checks++;
            if (pulse_ok !== 1'b1) begin
                errors++;
                $display("FAIL %s_done_pulse op=%h: done/busy not low after done cycle", tag, v[i].op);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/zero=%b expected 000", {bus.busy, bus.done, bus.zero});
        end
        checks++;
        if (bus.data_out !== 32'h0 || bus.shift_count !== 6'd0) begin
            errors++;
            $display("FAIL reset_outputs: got data_out=%h shift_count=%0d expected 0/0", bus.data_out, bus.shift_count);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_unsigned();
        vec_t v[];
        v = new[5];
        v[0] = '{32'h8000_0000, 1'b0, 32'h8000_0000, 6'd0,  1'b0, 1,  1};
        v[1] = '{32'h0001_0000, 1'b0, 32'h8000_0000, 6'd15, 1'b0, 16, 9};
        v[2] = '{32'h0000_0001, 1'b0, 32'h8000_0000, 6'd31, 1'b0, 32, 11};
        v[3] = '{32'h0F0F_0000, 1'b0, 32'hF0F0_0000, 6'd4,  1'b0, 5,  5};
        v[4] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 6'd32, 1'b1, 1,  1};
        check_vectors("unsigned", v);
    endtask

    task automatic test_signed();
        vec_t v[];
        v = new[6];
        v[0] = '{32'hFFFF_FFF0, 1'b1, 32'h8000_0000, 6'd27, 1'b0, 28, 7};
        v[1] = '{32'h0000_0003, 1'b1, 32'h6000_0000, 6'd29, 1'b0, 30, 9};
        v[2] = '{32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 6'd31, 1'b0, 32, 11};
        v[3] = '{32'h8000_0000, 1'b1, 32'h8000_0000, 6'd0,  1'b0, 1,  1};
        v[4] = '{32'h4000_0000, 1'b1, 32'h4000_0000, 6'd0,  1'b0, 1,  1};
        v[5] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 6'd0,  1'b1, 1,  1};
        check_vectors("signed", v);
    endtask

    task automatic test_start_while_busy();
        int done_seen;
        bus.start       = 1'b1;
        bus.data_in     = 32'h0001_0000;
        bus.signed_mode = 1'b0;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        bus.start       = 1'b1;
        bus.data_in     = 32'h0000_0001;
        bus.signed_mode = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 100; n++) begin
            if (bus.done === 1'b1) begin
                done_seen = 1;
                break;
            end
            @(posedge clock); #1;
        end
        checks++;
        if (done_seen != 1) begin
            errors++;
            $display("FAIL busy_start_done: got no done within bound, expected one");
        end
        checks++;
        if (bus.data_out !== 32'h8000_0000 || bus.shift_count !== 6'd15) begin
            errors++;
            $display("FAIL busy_start_result: got %h/%0d expected 80000000/15", bus.data_out, bus.shift_count);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] q;
        logic [5:0]  sc;
        logic        z;
        int          lat;
        int          extra;
        bus.start       = 1'b1;
        bus.data_in     = 32'h8000_0000;
        bus.signed_mode = 1'b0;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done: got %b expected 1", bus.done);
        end
        // Re-request on the done cycle; it must be dropped.
        bus.start   = 1'b1;
        bus.data_in = 32'h0000_0001;
        @(posedge clock); #1;
        bus.start = 1'b0;
        extra = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
            @(posedge clock); #1;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL b2b_ignored: got %0d busy/done cycles expected 0", extra);
        end
        checks++;
        if (bus.data_out !== 32'h8000_0000 || bus.shift_count !== 6'd0) begin
            errors++;
            $display("FAIL b2b_hold: got %h/%0d expected 80000000/0", bus.data_out, bus.shift_count);
        end
        q = 32'h0; sc = 6'd0; z = 1'b0; lat = 0;
    endtask

    task automatic test_reset_mid_shift();
        int done_seen;
        bus.start       = 1'b1;
        bus.data_in     = 32'h0000_0001;
        bus.signed_mode = 1'b0;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flags: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
        end
        checks++;
        if (bus.data_out !== 32'h0 || bus.shift_count !== 6'd0 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h/%0d/%b expected 0/0/0", bus.data_out, bus.shift_count, bus.zero);
        end
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock); #1;
            if (bus.done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d done pulses expected 0", done_seen);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.data_in     = 32'h0;
        test_reset();
        test_unsigned();
        test_signed();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
